// File: rtl/booth_acc_pkg.sv
// Shared types and constant helpers for the Booth product accumulator.
// Build option: ACC_SATURATE_EN selects clamping instead of wrapping adds.
package booth_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Most-positive (neg = 0) or most-negative (neg = 1) value of a w-bit signed number.
  function automatic logic signed [63:0] signed_limit(input int w, input logic neg);
    if (neg) return -(64'sd1 <<< (w - 1));
    else     return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Term counter width: enough to hold 0..terms.
  function automatic int cnt_width(input int terms);
    return (terms < 1) ? 1 : $clog2(terms + 1);
  endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product-in / sum-out handshake bundle for booth_product_accumulator.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; the sender holds valid and its data stable until that edge.
interface booth_product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
);
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              sum_valid;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum_data;
  logic              sum_ovf;

  modport master (
    output prod_valid, prod_data, sum_ready,
    input  prod_ready, sum_valid, sum_data, sum_ovf
  );

  modport slave (
    input  prod_valid, prod_data, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_ovf
  );
endinterface

// File: rtl/booth_acc_sat_add.sv
// Combinational signed adder with overflow flag.
// With ACC_SATURATE_EN defined an overflowing result clamps to the signed limit.
module booth_acc_sat_add
  import booth_acc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

`ifdef ACC_SATURATE_EN
  localparam logic signed [W-1:0] MAX_V = W'(signed_limit(W, 1'b0));
  localparam logic signed [W-1:0] MIN_V = W'(signed_limit(W, 1'b1));
`endif

  logic signed [W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow: operands agree in sign but the result does not.
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef ACC_SATURATE_EN
    sum = ovf ? (a[W-1] ? MIN_V : MAX_V) : raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates TERMS signed products into one ACC_W-bit sum and holds it until taken.
// Build option: ACC_SATURATE_EN (saturating accumulator adds).
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int TERMS  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  booth_product_accumulator_if.slave  bus,
  output acc_state_t                  fsm_state
);

  localparam int CNT_W = cnt_width(TERMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

  acc_state_t               state, state_next;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf;
  logic [ACC_W-1:0]         sum_q;
  logic                     sum_ovf_q;

  logic                     accept, last;
  logic signed [ACC_W-1:0]  prod_ext, add_sum;
  logic                     add_ovf;

  assign accept   = bus.prod_valid && (state == ACCUM);
  assign last     = accept && (cnt == CNT_LAST);
  assign prod_ext = ACC_W'(signed'(bus.prod_data));

  booth_acc_sat_add #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (last) state_next = HOLD;
      HOLD:    if (bus.sum_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // The terminal accept publishes the updated sum and restarts the partial sum from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        sum_q     <= add_sum;
        sum_ovf_q <= ovf | add_ovf;
      end else begin
        acc <= add_sum;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | add_ovf;
      end
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.sum_valid  = (state == HOLD);
  assign bus.sum_data   = sum_q;
  assign bus.sum_ovf    = sum_ovf_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: default build, a 9-bit accumulator for overflow cases, and TERMS = 1.
// Expected overflow results follow ACC_SATURATE_EN when it is defined for the build.
module tb_booth_product_accumulator;
  import booth_acc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  acc_state_t state_a, state_b, state_c;

  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) bus_a ();
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(9))  bus_b ();
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) bus_c ();

  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .TERMS(4)) u_dflt (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .fsm_state(state_a));
  booth_product_accumulator #(.PROD_W(8), .ACC_W(9), .TERMS(4)) u_narrow (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .fsm_state(state_b));
  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .TERMS(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave), .fsm_state(state_c));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef ACC_SATURATE_EN
  localparam logic [8:0] EXP_POS = 9'h0FF;
  localparam logic [8:0] EXP_NEG = 9'h100;
`else
  localparam logic [8:0] EXP_POS = 9'h1FC;
  localparam logic [8:0] EXP_NEG = 9'h000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks: present one product for one accepting edge
  task automatic send_a(input logic [7:0] d);
    bus_a.prod_valid = 1'b1;
    bus_a.prod_data  = d;
    tick();
    bus_a.prod_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    bus_b.prod_valid = 1'b1;
    bus_b.prod_data  = d;
    tick();
    bus_b.prod_valid = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] d);
    bus_c.prod_valid = 1'b1;
    bus_c.prod_data  = d;
    tick();
    bus_c.prod_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.prod_valid = 1'b0; bus_a.prod_data = '0; bus_a.sum_ready = 1'b1;
    bus_b.prod_valid = 1'b0; bus_b.prod_data = '0; bus_b.sum_ready = 1'b1;
    bus_c.prod_valid = 1'b0; bus_c.prod_data = '0; bus_c.sum_ready = 1'b1;
    #2;

    // reset state
    check("rst_prod_ready", 32'(bus_a.prod_ready), 32'h1);
    check("rst_sum_valid",  32'(bus_a.sum_valid),  32'h0);
    check("rst_sum_data",   32'(bus_a.sum_data),   32'h0);
    check("rst_sum_ovf",    32'(bus_a.sum_ovf),    32'h0);
    check("rst_state",      32'(state_a),          32'(ACCUM));
    tick();
    rst_n = 1'b1;
    tick();

    // basic sum: 12 - 7 + 49 - 64 = -10
    send_a(8'd12);
    send_a(8'hF9);
    send_a(8'd49);
    check("basic_busy_valid", 32'(bus_a.sum_valid), 32'h0);
    send_a(8'hC0);
    check("basic_sum_valid", 32'(bus_a.sum_valid),  32'h1);
    check("basic_sum_data",  32'(bus_a.sum_data),   32'hFFF6);
    check("basic_sum_ovf",   32'(bus_a.sum_ovf),    32'h0);
    check("basic_hold_rdy",  32'(bus_a.prod_ready), 32'h0);
    check("basic_state",     32'(state_a),          32'(HOLD));
    tick();
    check("basic_back_rdy",  32'(bus_a.prod_ready), 32'h1);
    check("basic_back_vld",  32'(bus_a.sum_valid),  32'h0);

    // backpressure: consumer stalls 5 cycles while upstream holds the next product (3)
    bus_a.sum_ready = 1'b0;
    send_a(8'd12);
    send_a(8'hF9);
    send_a(8'd49);
    send_a(8'hC0);
    bus_a.prod_valid = 1'b1;
    bus_a.prod_data  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum_valid",  32'(bus_a.sum_valid),  32'h1);
      check("bp_sum_data",   32'(bus_a.sum_data),   32'hFFF6);
      check("bp_prod_ready", 32'(bus_a.prod_ready), 32'h0);
      tick();
    end
    bus_a.sum_ready = 1'b1;
    tick();
    check("bp_release_rdy", 32'(bus_a.prod_ready), 32'h1);
    send_a(8'd3);
    send_a(8'd1);
    send_a(8'd1);
    send_a(8'd1);
    check("bp_next_valid", 32'(bus_a.sum_valid), 32'h1);
    check("bp_next_data",  32'(bus_a.sum_data),  32'h0006);
    tick();

    // 9-bit accumulator: 127 x4
    for (int i = 0; i < 4; i++) send_b(8'd127);
    check("pos_ovf_valid", 32'(bus_b.sum_valid), 32'h1);
    check("pos_ovf_data",  32'(bus_b.sum_data),  32'(EXP_POS));
    check("pos_ovf_flag",  32'(bus_b.sum_ovf),   32'h1);
    tick();

    // 9-bit accumulator: -128 x4
    for (int i = 0; i < 4; i++) send_b(8'h80);
    check("neg_ovf_data", 32'(bus_b.sum_data), 32'(EXP_NEG));
    check("neg_ovf_flag", 32'(bus_b.sum_ovf),  32'h1);
    tick();

    // clean sum after an overflowing one
    for (int i = 0; i < 4; i++) send_b(8'd1);
    check("clear_data", 32'(bus_b.sum_data), 32'h004);
    check("clear_flag", 32'(bus_b.sum_ovf),  32'h0);
    tick();

    // reset mid-sum discards 5 + 6
    send_a(8'd5);
    send_a(8'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_prod_ready", 32'(bus_a.prod_ready), 32'h1);
    check("midrst_sum_valid",  32'(bus_a.sum_valid),  32'h0);
    check("midrst_sum_data",   32'(bus_a.sum_data),   32'h0);
    tick();
    check("midrst_hold_data",  32'(bus_a.sum_data),   32'h0);
    rst_n = 1'b1;
    send_a(8'd1);
    send_a(8'd2);
    send_a(8'd3);
    send_a(8'd4);
    check("midrst_sum_valid2", 32'(bus_a.sum_valid), 32'h1);
    check("midrst_sum",        32'(bus_a.sum_data),  32'h000A);
    check("midrst_ovf",        32'(bus_a.sum_ovf),   32'h0);
    tick();

    // TERMS = 1 with idle gaps
    tick();
    check("t1_idle_valid", 32'(bus_c.sum_valid), 32'h0);
    send_c(8'hFD);
    check("t1_a_valid", 32'(bus_c.sum_valid),  32'h1);
    check("t1_a_data",  32'(bus_c.sum_data),   32'hFFFD);
    check("t1_a_ovf",   32'(bus_c.sum_ovf),    32'h0);
    check("t1_a_rdy",   32'(bus_c.prod_ready), 32'h0);
    tick();
    check("t1_back_valid", 32'(bus_c.sum_valid),  32'h0);
    check("t1_back_rdy",   32'(bus_c.prod_ready), 32'h1);
    tick();
    tick();
    send_c(8'd100);
    check("t1_b_valid", 32'(bus_c.sum_valid), 32'h1);
    check("t1_b_data",  32'(bus_c.sum_data),  32'h0064);
    tick();
    check("t1_b_done",  32'(bus_c.sum_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

- Downstream stage of the sequential signed Booth multiplier.
- Consumes a stream of signed products over a valid/ready handshake and accumulates TERMS consecutive products into a wider signed sum.
- Presents each finished sum, with an overflow flag, on a held output handshake.
- Sits between the multiplier and the dot-product / filter logic that reads completed sums.

## Interface
- PROD_W, 8, signed product width; matches the multiplier's product output.
- ACC_W, 16, signed accumulator and sum width; must be at least PROD_W + 1.
- TERMS, 4, products per sum; must be at least 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- prod_valid  input  1  prod_data is valid this cycle.
- prod_ready  output  1  block accepts a product this cycle.
- prod_data  input  PROD_W  signed product, sign-extended to ACC_W before adding.
- sum_valid  output  1  sum_data and sum_ovf are valid.
- sum_ready  input  1  consumer takes the sum this cycle.
- sum_data  output  ACC_W  completed signed sum.
- sum_ovf  output  1  at least one add in this sum overflowed ACC_W.

## Operation
- Two states.
  - ACCUM: prod_ready = 1, sum_valid = 0.
  - HOLD: prod_ready = 0, sum_valid = 1.
- Accept: prod_valid && prod_ready.
  - acc <= acc + sext(prod_data).
  - cnt <= cnt + 1.
  - Overflow is detected when both operands share a sign and the result sign differs. It sets a sticky ovf bit.
- Accept with cnt == TERMS-1:
  - Move to HOLD.
  - sum_data <= the updated acc value; sum_ovf <= the updated sticky bit.
  - Clear acc, cnt and ovf.
- HOLD with sum_ready = 1: return to ACCUM.
- HOLD with sum_ready = 0: stay in HOLD; sum_data and sum_ovf remain stable.
- No product is accepted in HOLD. Upstream must hold prod_valid and prod_data until prod_ready returns.
- prod_data is ignored when prod_valid = 0.
- TERMS = 1: every accepted product goes straight to HOLD, and sum_data is the sign-extended product.
- cnt is ceil(log2(TERMS+1)) bits. It never wraps, because it is cleared on the terminal accept.

## Timing
- Reset values:
  - State: ACCUM.
  - prod_ready = 1, sum_valid = 0.
  - sum_data = 0, sum_ovf = 0.
  - acc = 0, cnt = 0, ovf = 0.
- Asserting rst_n mid-sum or while in HOLD discards the partial or pending sum immediately. Deasserting it takes effect on the next clk edge.
- All outputs are registered; no input-to-output combinational path.
- Latency: sum_valid rises in the cycle after the terminal product is accepted.
- Throughput:
  - One product per cycle in ACCUM.
  - One bubble per sum: the HOLD cycle.
  - Best case is TERMS+1 cycles per sum.
- sum_ready asserted in the first HOLD cycle: prod_ready = 1 in the following cycle.

## Configuration
- ACC_SATURATE_EN defined:
  - An overflowing add clamps the accumulator to the most-positive value (2^(ACC_W-1)-1) or the most-negative value (-2^(ACC_W-1)), following the operands' sign.
  - Later adds continue from the clamped value.
  - sum_ovf is set.
- ACC_SATURATE_EN undefined:
  - The add wraps modulo 2^ACC_W.
  - sum_ovf is still set.
- Handshake and timing are identical in both builds.

## Structure
- Package booth_acc_pkg holds:
  - the state enum (ACCUM, HOLD);
  - a function returning the signed max/min constants for a given width;
  - the cnt-width helper.
- Sub-module booth_acc_sat_add:
  - Purely combinational ACC_W signed adder.
  - Outputs the sum and an overflow bit.
  - Contains the saturation mux under ACC_SATURATE_EN.
  - Instanced once in the accumulator datapath.

## Test plan
- Basic sum, defaults, back-to-back valid, sum_ready = 1:
  - Products 12, -7, 49, -64 -> sum_valid in the cycle after the 4th accept.
  - sum_data = 16'hFFF6 (-10), sum_ovf = 0.
- Backpressure:
  - Same stream with sum_ready = 0 for 5 cycles -> sum_valid and sum_data stable for 5 cycles, prod_ready = 0 throughout.
  - Next product accepted the cycle after sum_ready = 1.
- Overflow, ACC_W = 9, products 127 x4:
  - ACC_SATURATE_EN defined -> sum_data = 9'h0FF, sum_ovf = 1.
  - ACC_SATURATE_EN undefined -> sum_data = 9'h1FC (-4), sum_ovf = 1.
- Negative extreme, ACC_W = 9, products -128 x4:
  - ACC_SATURATE_EN defined -> sum_data = 9'h100 (-256), sum_ovf = 1.
  - Next sum of 1, 1, 1, 1 -> sum_data = 4, sum_ovf = 0, confirming the clear between sums.
- Reset mid-sum:
  - Accept 5 and 6, assert rst_n low for 1 cycle, then send 1, 2, 3, 4.
  - sum_data = 10; the earlier partials are discarded.
  - Outputs read reset values while rst_n is low.
- TERMS = 1 with gaps:
  - prod_valid toggling, products -3 then 100 -> two sums, -3 (ACC_W'h...FFD) then 100, each appearing the cycle after its accept.
